// File: rtl/eacs_radix_pipe.sv
// Pipelined add-compare-select over 2**K branches of W-bit path metrics:
// saturating add + optional normalisation, K registered compare levels, output register.
module eacs_radix_pipe #(
    parameter int unsigned W  = 4,
    parameter int unsigned K  = 2,
    parameter int unsigned CW = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ae,
    input  logic [(2**K)*W-1:0]   ppm_in,
    input  logic [(2**K)*W-1:0]   hd_in,
    input  logic                  norm_en,
    input  logic [W-1:0]          norm_val,
    input  logic                  clr_cnt,
    output logic [W-1:0]          ppm_out,
    output logic [K-1:0]          bx_out,
    output logic                  valid_out,
    output logic [CW-1:0]         sat_count
);

    localparam int unsigned N     = 2**K;
    localparam int unsigned NODES = 2*N - 1;
    localparam logic [W-1:0] MAX  = '1;

    // Tree nodes live in one flat array: level 0 (stage-0 sums) at 0..N-1,
    // level l at offs(l) .. offs(l)+(N>>l)-1, root at NODES-1.
    function automatic int unsigned offs(input int unsigned l);
        return 2*N - ((2*N) >> l);
    endfunction

    logic [W:0]   w_t   [N];
    logic [W-1:0] w_s   [N];
    logic [N-1:0] w_ovf;

    logic [W-1:0] r_m [NODES];
    logic [K-1:0] r_x [NODES];
    logic [K:0]   r_v;

    always_comb begin
        w_ovf = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_t[i] = {1'b0, ppm_in[i*W +: W]} + {1'b0, hd_in[i*W +: W]};
            if (ppm_in[i*W +: W] == MAX) begin
                w_s[i] = MAX;
            end else if (w_t[i][W]) begin
                w_s[i]   = MAX;
                w_ovf[i] = 1'b1;
            end else begin
                w_s[i] = w_t[i][W-1:0];
            end
            if (norm_en && (w_s[i] != MAX)) begin
                w_s[i] = (w_s[i] >= norm_val) ? (w_s[i] - norm_val) : '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned n = 0; n < NODES; n++) begin
                r_m[n] <= '0;
                r_x[n] <= '0;
            end
            r_v       <= '0;
            ppm_out   <= '0;
            bx_out    <= '0;
            valid_out <= 1'b0;
        end else begin
            r_v <= {r_v[K-1:0], ae};
            if (ae) begin
                for (int unsigned i = 0; i < N; i++) begin
                    r_m[i] <= w_s[i];
                end
            end
            // Ties resolve to the left (lower-index) input; the right winner sets bit l-1.
            for (int unsigned l = 1; l <= K; l++) begin
                if (r_v[l-1]) begin
                    for (int unsigned j = 0; j < (N >> l); j++) begin
                        if (r_m[offs(l-1) + 2*j] <= r_m[offs(l-1) + 2*j + 1]) begin
                            r_m[offs(l) + j] <= r_m[offs(l-1) + 2*j];
                            r_x[offs(l) + j] <= r_x[offs(l-1) + 2*j];
                        end else begin
                            r_m[offs(l) + j] <= r_m[offs(l-1) + 2*j + 1];
                            r_x[offs(l) + j] <= r_x[offs(l-1) + 2*j + 1] | (K'(1) << (l - 1));
                        end
                    end
                end
            end
            valid_out <= r_v[K];
            if (r_v[K]) begin
                ppm_out <= r_m[NODES-1];
                bx_out  <= r_x[NODES-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sat_count <= '0;
        end else if (clr_cnt) begin
            sat_count <= '0;
        end else if (ae && (|w_ovf) && (sat_count != '1)) begin
            sat_count <= sat_count + 1'b1;
        end
    end

endmodule
